systolic_feed_ctrl: RTL

Sequencing controller for an N x N systolic multiply array of minifloat PEs. It buffers operand matrices A and B, then streams them into the array's west (A rows) and north (B columns) edges with the diagonal skew the array requires. After feeding, it holds the array for a fixed flush interval and signals completion. It sits between the host load interface and the PE grid top level.

---
 rtl/systolic_feed_ctrl_pkg.sv | 27 ++
 rtl/systolic_feed_ctrl_if.sv | 39 +++
 rtl/systolic_feed_ctrl_skew_lane_mux.sv | 29 ++
 rtl/systolic_feed_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic feed controller.
// Holds the FSM state type, default sizing, and small helpers for index widths
// and lane packing used by the interface, the top level and the lane muxes.
package systolic_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StFlush,
    StDone
  } state_e;

  localparam int unsigned DefN     = 3;
  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefFlush = 9;

  // Width needed to index n items; never below one bit so N=1-style corners stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of lane k inside a packed bus of dw-wide lanes.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Host-load and array-edge signal bundle for systolic_feed_ctrl.
// master: host side (drives start/load, observes status and edges).
// slave : controller side.
// Signals: start, ld_en, ld_sel, ld_row, ld_col, ld_data (host -> ctrl);
//          busy, done, feed_valid, pe_l, a_west, b_north (ctrl -> host/array).
interface systolic_feed_ctrl_if
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw
);

  localparam int unsigned IW = idx_w(N);

  logic          start;
  logic          ld_en;
  logic          ld_sel;
  logic [IW-1:0] ld_row;
  logic [IW-1:0] ld_col;
  logic [DW-1:0] ld_data;

  logic            busy;
  logic            done;
  logic            feed_valid;
  logic            pe_l;
  logic [N*DW-1:0] a_west;
  logic [N*DW-1:0] b_north;

  modport master (
    output start, ld_en, ld_sel, ld_row, ld_col, ld_data,
    input  busy, done, feed_valid, pe_l, a_west, b_north
  );

  modport slave (
    input  start, ld_en, ld_sel, ld_row, ld_col, ld_data,
    output busy, done, feed_valid, pe_l, a_west, b_north
  );

endinterface

// File: rtl/systolic_feed_ctrl_skew_lane_mux.sv
// Skew selector for one array edge lane.
// Lane K carries element [beat-K] of its row/column vector, and zero whenever
// beat-K falls outside 0..N-1.
// Ports: beat  - current beat index
//        elems - N packed elements, element e at bits e*DW +: DW
//        lane  - selected element or zero
module systolic_feed_ctrl_skew_lane_mux
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw,
  parameter int unsigned K  = 0,
  parameter int unsigned TW = 3
) (
  input  logic [TW-1:0]   beat,
  input  logic [N*DW-1:0] elems,
  output logic [DW-1:0]   lane
);

  always_comb begin
    lane = '0;
    for (int unsigned e = 0; e < N; e++) begin
      if (32'(beat) == K + e) begin
        lane = elems[lane_lsb(e, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencing controller for an N x N systolic multiply array.
// Buffers operand matrices A and B while idle, then streams A rows into the west
// edge and B columns into the north edge with diagonal skew, holds for FLUSH
// cycles, and pulses done.
// Ports: clk, rst_n (synchronous, active low)
//        bus - slave side of systolic_feed_ctrl_if (load port, status, edges)
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned FLUSH = DefFlush
) (
  input  logic           clk,
  input  logic           rst_n,
  systolic_feed_ctrl_if.slave bus
);

  localparam int unsigned TW       = idx_w(2 * N - 1);
  localparam int unsigned FW       = idx_w(FLUSH);
  localparam int unsigned LastBeat = 2 * N - 2;

  state_e        state_q, state_d;
  logic [TW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;

  logic [DW-1:0] buf_a_q [N][N];
  logic [DW-1:0] buf_a_d [N][N];
  logic [DW-1:0] buf_b_q [N][N];
  logic [DW-1:0] buf_b_d [N][N];

  logic [N-1:0][N*DW-1:0] a_rows;
  logic [N-1:0][N*DW-1:0] b_cols;
  logic [N*DW-1:0]        a_beat, b_beat;
  logic [N*DW-1:0]        a_west_q, a_west_d;
  logic [N*DW-1:0]        b_north_q, b_north_d;
  logic                   ld_ok;

  // Operand buffers: writable only while idle, out-of-range indices dropped.
  always_comb begin
    ld_ok = (state_q == StIdle) && bus.ld_en &&
            (32'(bus.ld_row) < N) && (32'(bus.ld_col) < N);
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    if (ld_ok) begin
      if (bus.ld_sel) buf_b_d[bus.ld_row][bus.ld_col] = bus.ld_data;
      else            buf_a_d[bus.ld_row][bus.ld_col] = bus.ld_data;
    end
  end

  // Lane vectors are built from the next-state buffers so a load coinciding
  // with start is already visible to the first beats of that run.
  always_comb begin
    a_rows = '0;
    b_cols = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        a_rows[i][lane_lsb(k, DW) +: DW] = buf_a_d[i][k];
        b_cols[i][lane_lsb(k, DW) +: DW] = buf_b_d[k][i];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    systolic_feed_ctrl_skew_lane_mux #(
      .N (N),
      .DW(DW),
      .K (k),
      .TW(TW)
    ) u_a_mux (
      .beat (beat_d),
      .elems(a_rows[k]),
      .lane (a_beat[k*DW +: DW])
    );

    systolic_feed_ctrl_skew_lane_mux #(
      .N (N),
      .DW(DW),
      .K (k),
      .TW(TW)
    ) u_b_mux (
      .beat (beat_d),
      .elems(b_cols[k]),
      .lane (b_beat[k*DW +: DW])
    );
  end

  // FSM next state and counters.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFeed;
          beat_d  = '0;
        end
      end
      StFeed: begin
        if (beat_q == TW'(LastBeat)) begin
          state_d = StFlush;
          flush_d = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StFlush: begin
        if (flush_q == FW'(FLUSH - 1)) state_d = StDone;
        else                           flush_d = flush_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Edge data is registered for the beat the FSM is about to enter.
  always_comb begin
    a_west_d  = (state_d == StFeed) ? a_beat : '0;
    b_north_d = (state_d == StFeed) ? b_beat : '0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_a_q   <= '{default: '0};
      buf_b_q   <= '{default: '0};
      a_west_q  <= '0;
      b_north_q <= '0;
    end else begin
      buf_a_q   <= buf_a_d;
      buf_b_q   <= buf_b_d;
      a_west_q  <= a_west_d;
      b_north_q <= b_north_d;
    end
  end

  // FSM outputs.
  always_comb begin
    bus.busy       = (state_q == StFeed) || (state_q == StFlush);
    bus.done       = (state_q == StDone);
    bus.feed_valid = (state_q == StFeed);
    bus.pe_l       = (state_q == StFeed);
    bus.a_west     = a_west_q;
    bus.b_north    = b_north_q;
  end

endmodule
